riscv_regfile_wr_ctrl: RTL

RISCV_REGFILE_WR_CTRL -- requirements
Module: riscv_regfile_wr_ctrl

---
 rtl/riscv_regfile_pkg.sv | 19 +
 rtl/riscv_regfile_wr_ctrl_if.sv | 28 ++
 rtl/riscv_rr_arb2.sv | 35 +++
 rtl/riscv_regfile_wr_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/riscv_regfile_pkg.sv
// Shared widths, FSM state type and write-request payload for the regfile
// write controller. Optional power-up sweep: RISCV_REGFILE_INIT_EN.
package riscv_regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_W-1:0]      value;
  } wr_req_t;

endpackage

// File: rtl/riscv_regfile_wr_ctrl_if.sv
// Bundle of the two requester handshakes plus the regfile write port.
// master = requester/bench side, slave = write controller side.
interface riscv_regfile_wr_ctrl_if;
  import riscv_regfile_pkg::*;

  logic                  a_valid;
  logic [REG_ADDR_W-1:0] a_rd;
  logic [REG_W-1:0]      a_value;
  logic                  a_ready;
  logic                  b_valid;
  logic [REG_ADDR_W-1:0] b_rd;
  logic [REG_W-1:0]      b_value;
  logic                  b_ready;
  logic [REG_ADDR_W-1:0] rd0;
  logic [REG_W-1:0]      rd0_value;
  logic                  busy;

  modport master (
    output a_valid, a_rd, a_value, b_valid, b_rd, b_value,
    input  a_ready, b_ready, rd0, rd0_value, busy
  );

  modport slave (
    input  a_valid, a_rd, a_value, b_valid, b_rd, b_value,
    output a_ready, b_ready, rd0, rd0_value, busy
  );

endinterface

// File: rtl/riscv_rr_arb2.sv
// Two-input round-robin arbiter; ptr_q=0 favours requester 0 (A).
module riscv_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  // Grant the sole requester, or the favoured one on contention; move the
  // favour to the other side after every grant.
  always_comb begin
    grant = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0];
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/riscv_regfile_wr_ctrl.sv
// Register file write-port controller: optional x1..x31 init sweep, then
// round-robin arbitration between ALU (A) and load (B) writeback.
// Sweep compiled in only when RISCV_REGFILE_INIT_EN is defined.
module riscv_regfile_wr_ctrl
  import riscv_regfile_pkg::*;
#(
  parameter logic [REG_W-1:0] INIT_VALUE = 32'h00000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_valid_i,
  input  logic [REG_ADDR_W-1:0] a_rd_i,
  input  logic [REG_W-1:0]      a_value_i,
  output logic                  a_ready_o,
  input  logic                  b_valid_i,
  input  logic [REG_ADDR_W-1:0] b_rd_i,
  input  logic [REG_W-1:0]      b_value_i,
  output logic                  b_ready_o,
  output logic [REG_ADDR_W-1:0] rd0_o,
  output logic [REG_W-1:0]      rd0_value_o,
  output logic                  busy_o
);

  logic                  run_c;
  logic [1:0]            req_c;
  logic [1:0]            grant_c;
  wr_req_t               sel_c;
  logic [REG_ADDR_W-1:0] rd0_q;
  logic [REG_ADDR_W-1:0] rd0_d;
  logic [REG_W-1:0]      rd0_value_q;
  logic [REG_W-1:0]      rd0_value_d;

`ifdef RISCV_REGFILE_INIT_EN
  localparam logic [REG_ADDR_W-1:0] LAST_REG   = REG_ADDR_W'(NUM_REGS - 1);
  localparam logic [REG_W-1:0]      IDLE_VALUE = '0;

  state_e                state_q;
  state_e                state_d;
  logic [REG_ADDR_W-1:0] cnt_q;
  logic [REG_ADDR_W-1:0] cnt_d;

  assign run_c  = (state_q == RUN);
  assign busy_o = (state_q == INIT);
`else
  // The sweep value has no role without the sweep; fold it to zero.
  localparam logic [REG_W-1:0] IDLE_VALUE = INIT_VALUE & REG_W'(0);

  assign run_c  = 1'b1;
  assign busy_o = 1'b0;
`endif

  // Requests only compete in RUN and never while reset is held.
  assign req_c = {b_valid_i, a_valid_i} & {2{run_c & ~rst_i}};

  riscv_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req_c),
    .advance (run_c),
    .grant   (grant_c)
  );

  assign a_ready_o   = grant_c[0];
  assign b_ready_o   = grant_c[1];
  assign rd0_o       = rd0_q;
  assign rd0_value_o = rd0_value_q;

  // Next write-port value: sweep entry, granted request, or idle.
  always_comb begin
    rd0_d       = '0;
    rd0_value_d = IDLE_VALUE;
    sel_c       = '0;
    if (grant_c[0]) begin
      sel_c = '{rd: a_rd_i, value: a_value_i};
    end else if (grant_c[1]) begin
      sel_c = '{rd: b_rd_i, value: b_value_i};
    end
    if (grant_c != 2'b00) begin
      rd0_d       = sel_c.rd;
      rd0_value_d = sel_c.value;
    end
`ifdef RISCV_REGFILE_INIT_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      rd0_d       = cnt_q;
      rd0_value_d = INIT_VALUE;
      cnt_d       = cnt_q + REG_ADDR_W'(1);
      if (cnt_q == LAST_REG) begin
        state_d = RUN;
      end
    end
`endif
  end

  // Write-port, state and sweep-counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd0_q       <= '0;
      rd0_value_q <= '0;
`ifdef RISCV_REGFILE_INIT_EN
      state_q     <= INIT;
      cnt_q       <= REG_ADDR_W'(1);
`endif
    end else begin
      rd0_q       <= rd0_d;
      rd0_value_q <= rd0_value_d;
`ifdef RISCV_REGFILE_INIT_EN
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule
